// File: rtl/sim_axi_master_addr_chan.sv
// sim_axi_master_addr_chan
//   Simulation-side AXI3 master address-channel queue. Commands written through
//   set_cmd are stored in a DEPTH-entry FIFO, held back for LATENCY cycles and
//   then presented with valid until the slave accepts them (valid_in).
//   Also reused for AW and for the write-data channel with a different payload.
//
// Ports
//   clk, reset                      clock (rising edge), synchronous active-high reset
//   id_in .. prot_in, set_cmd       command payload and capture strobe
//   ready                           queue not full (registered state only)
//   id .. prot                      head-of-queue payload, zero while valid=0
//   valid                           AXI valid
//   valid_in                        AXI ready from the slave
//
// DATA_DELAY / VALID_DELAY describe output transport delays of the behavioural
// model; they do not affect cycle behaviour and are not applied in this RTL.
module sim_axi_master_addr_chan #(
  parameter int  ID_WIDTH      = 12,
  parameter int  ADDRESS_WIDTH = 32,
  parameter int  LATENCY       = 0,
  parameter int  DEPTH         = 8,
  parameter real DATA_DELAY    = 3.5,
  parameter real VALID_DELAY   = 4.0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ID_WIDTH-1:0]      id_in,
  input  logic [ADDRESS_WIDTH-1:0] addr_in,
  input  logic [3:0]               len_in,
  input  logic [2:0]               size_in,
  input  logic [1:0]               burst_in,
  input  logic [3:0]               cache_in,
  input  logic [2:0]               prot_in,
  input  logic                     set_cmd,
  output logic                     ready,
  output logic [ID_WIDTH-1:0]      id,
  output logic [ADDRESS_WIDTH-1:0] addr,
  output logic [3:0]               len,
  output logic [2:0]               size,
  output logic [1:0]               burst,
  output logic [3:0]               cache,
  output logic [2:0]               prot,
  output logic                     valid,
  input  logic                     valid_in
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int PLW = ID_WIDTH + ADDRESS_WIDTH + 4 + 3 + 2 + 4 + 3;

  // Elaboration-time sanity of parameters; an illegal set leaves a marker block.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (LATENCY < 0) ||
      (DATA_DELAY < 0.0) || (VALID_DELAY < 0.0)) begin : g_bad_params
  end

  logic [PLW-1:0] mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  occ_q, occ_d;
  logic [CW-1:0]  avail_q, avail_d;
  logic           push_s;
  logic           pop_s;
  logic           avail_inc_s;
  logic [PLW-1:0] head_s;

  assign ready  = (occ_q < CW'(DEPTH));
  assign valid  = (avail_q != {CW{1'b0}});
  assign push_s = set_cmd & ready;
  assign pop_s  = valid & valid_in;

  // Delayed push strobe: an entry becomes poppable LATENCY edges after capture.
  if (LATENCY == 0) begin : g_lat0
    assign avail_inc_s = push_s;
  end else begin : g_latn
    logic [LATENCY-1:0] push_sr_q;

    // Push-strobe shift register; cleared on reset so no stale entry turns valid.
    always_ff @(posedge clk) begin
      if (reset) begin
        push_sr_q <= {LATENCY{1'b0}};
      end else begin
        push_sr_q <= (push_sr_q << 1) | LATENCY'(push_s);
      end
    end

    assign avail_inc_s = push_sr_q[LATENCY-1];
  end

  // Next-state for pointers and counters.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    avail_d  = avail_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    occ_d   = occ_q + CW'(push_s) - CW'(pop_s);
    avail_d = avail_q + CW'(avail_inc_s) - CW'(pop_s);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      occ_q    <= {CW{1'b0}};
      avail_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      avail_q  <= avail_d;
    end
  end

  // Payload storage; contents are don't-care until valid, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {id_in, addr_in, len_in, size_in, burst_in, cache_in, prot_in};
    end
  end

  // Head payload is forced to zero while nothing is presented.
  assign head_s = valid ? mem_q[rd_ptr_q] : {PLW{1'b0}};
  assign {id, addr, len, size, burst, cache, prot} = head_s;

endmodule

// File: tb/tb_sim_axi_master_addr_chan.sv
// Directed self-checking bench for sim_axi_master_addr_chan.
// u_dut: LATENCY=0, DEPTH=8 (main tests). u_lat: LATENCY=2 (eligibility delay).
module tb_sim_axi_master_addr_chan;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] id_in;
  logic [31:0] addr_in;
  logic [3:0]  len_in;
  logic [2:0]  size_in;
  logic [1:0]  burst_in;
  logic [3:0]  cache_in;
  logic [2:0]  prot_in;
  logic        set_cmd;
  logic        ready;
  logic [11:0] id;
  logic [31:0] addr;
  logic [3:0]  len;
  logic [2:0]  size;
  logic [1:0]  burst;
  logic [3:0]  cache;
  logic [2:0]  prot;
  logic        valid;
  logic        valid_in;

  logic        l_set;
  logic [31:0] l_addr_in;
  logic        l_ready;
  logic [11:0] l_id;
  logic [31:0] l_addr;
  logic [3:0]  l_len;
  logic [2:0]  l_size;
  logic [1:0]  l_burst;
  logic [3:0]  l_cache;
  logic [2:0]  l_prot;
  logic        l_valid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sim_axi_master_addr_chan #(.LATENCY(0), .DEPTH(8)) u_dut (
    .clk(clk), .reset(reset),
    .id_in(id_in), .addr_in(addr_in), .len_in(len_in), .size_in(size_in),
    .burst_in(burst_in), .cache_in(cache_in), .prot_in(prot_in),
    .set_cmd(set_cmd), .ready(ready),
    .id(id), .addr(addr), .len(len), .size(size), .burst(burst),
    .cache(cache), .prot(prot), .valid(valid), .valid_in(valid_in)
  );

  sim_axi_master_addr_chan #(.LATENCY(2), .DEPTH(8)) u_lat (
    .clk(clk), .reset(reset),
    .id_in(12'h00A), .addr_in(l_addr_in), .len_in(4'h0), .size_in(3'h2),
    .burst_in(2'h1), .cache_in(4'h0), .prot_in(3'h0),
    .set_cmd(l_set), .ready(l_ready),
    .id(l_id), .addr(l_addr), .len(l_len), .size(l_size), .burst(l_burst),
    .cache(l_cache), .prot(l_prot), .valid(l_valid), .valid_in(1'b1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int sent;
  int recv;
  int budget;
  logic vin;

  initial begin
    reset = 1'b1; set_cmd = 1'b0; valid_in = 1'b0;
    id_in = 12'h0; addr_in = 32'h0; len_in = 4'h0; size_in = 3'h2;
    burst_in = 2'h1; cache_in = 4'h3; prot_in = 3'h0;
    l_set = 1'b0; l_addr_in = 32'h0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_addr",  64'(addr),  64'd0);
    check("rst_id",    64'(id),    64'd0);

    // Single command, slave always ready
    valid_in = 1'b1;
    id_in = 12'd5; addr_in = 32'h4000_0080; len_in = 4'd0; set_cmd = 1'b1;
    tick();
    set_cmd = 1'b0;
    check("single_valid", 64'(valid), 64'd1);
    check("single_addr",  64'(addr),  64'h4000_0080);
    check("single_id",    64'(id),    64'd5);
    check("single_ready", 64'(ready), 64'd1);
    tick();
    check("single_after", 64'(valid), 64'd0);

    // LATENCY=2 eligibility
    l_addr_in = 32'h0000_2000; l_set = 1'b1;
    tick();
    l_set = 1'b0;
    check("lat_n",   64'(l_valid), 64'd0);
    tick();
    check("lat_n1",  64'(l_valid), 64'd0);
    tick();
    check("lat_n2",  64'(l_valid), 64'd1);
    check("lat_addr", 64'(l_addr), 64'h2000);
    tick();
    check("lat_pop", 64'(l_valid), 64'd0);

    // Slave stall for 5 cycles
    valid_in = 1'b0;
    id_in = 12'd3; addr_in = 32'h0000_1000; len_in = 4'd7; set_cmd = 1'b1;
    tick();
    set_cmd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 64'(valid), 64'd1);
      check("stall_addr",  64'(addr),  64'h1000);
      check("stall_len",   64'(len),   64'd7);
      tick();
    end
    valid_in = 1'b1;
    tick();
    check("stall_pop", 64'(valid), 64'd0);

    // Queue full: 9 pushes, the 9th is dropped
    valid_in = 1'b0; len_in = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) check("full_ready", 64'(ready), 64'd0);
      id_in = 12'(i); addr_in = 32'(i * 4); set_cmd = 1'b1;
      tick();
    end
    // Push while full in the same cycle as the first pop is still dropped
    valid_in = 1'b1; addr_in = 32'h0000_0BAD; id_in = 12'hBAD; set_cmd = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("drain_valid", 64'(valid), 64'd1);
      check("drain_addr",  64'(addr),  64'(k * 4));
      check("drain_id",    64'(id),    64'(k));
      tick();
      set_cmd = 1'b0;
    end
    check("drain_empty", 64'(valid), 64'd0);
    check("drain_ready", 64'(ready), 64'd1);

    // Wrap-around stream with pseudo-random slave ready
    sent = 0; recv = 0; budget = 0;
    while ((recv < 20) && (budget < 500)) begin
      vin = 1'($urandom_range(0, 1));
      valid_in = vin;
      set_cmd = (sent < 20);
      addr_in = 32'h100 + 32'(sent * 4);
      id_in = 12'(sent);
      #1;
      if (valid && vin) begin
        check("wrap_addr", 64'(addr), 64'h100 + 64'(recv * 4));
        check("wrap_id",   64'(id),   64'(recv));
        recv++;
      end
      if (set_cmd && ready) sent++;
      tick();
      budget++;
    end
    set_cmd = 1'b0;
    check("wrap_count", 64'(recv), 64'd20);
    valid_in = 1'b1;
    tick(); tick();
    check("wrap_nodup", 64'(valid), 64'd0);

    // Reset mid-operation with 3 queued entries
    valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr_in = 32'hA0 + 32'(i); set_cmd = 1'b1;
      tick();
    end
    set_cmd = 1'b0;
    check("pre_rst_valid", 64'(valid), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_valid", 64'(valid), 64'd0);
    check("mrst_ready", 64'(ready), 64'd1);
    valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mrst_stale", 64'(valid), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
